// File: rtl/sync_fifo_param_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_pkg
//   Shared definitions for the clk_master write-buffer FIFO:
//   - fifo_mode_e : read-mode selector (standard registered read / FWFT)
//   - CLOG2       : ceiling log2, used to size pointers and the count port
// ---------------------------------------------------------------------------
package sync_fifo_param_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int unsigned CLOG2(input int unsigned value);
        int unsigned v;
        int unsigned res;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
//   DEPTH x DATA_W storage for sync_fifo_param. Synchronous write,
//   asynchronous (combinational) read. Contents are not reset.
// Ports
//   clk_master : write clock
//   wr_en      : write strobe (already qualified by the FIFO accept logic)
//   wr_addr    : write address
//   wr_data    : write data
//   rd_addr    : read address
//   rd_data    : combinational read data at rd_addr
// ---------------------------------------------------------------------------
module fifo_ram
    import sync_fifo_param_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = CLOG2(DEPTH)
) (
    input  logic              clk_master,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_master) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO buffering master write traffic ahead of the
//   master/memory CDC FIFO. Registered full/empty/almost flags derived from
//   the next occupancy, sticky overflow/underflow, and a choice of
//   registered-read (FWFT=0) or first-word-fall-through (FWFT=1) output.
// Ports
//   clk_master   : clock, all state on rising edge
//   reset        : asynchronous, active-high reset
//   wr_en        : write request
//   wr_data      : write data
//   rd_en        : read request (FWFT: pop current head)
//   rd_data      : read data
//   full         : count == DEPTH
//   empty        : count == 0
//   almost_full  : count >= AF_THRESH
//   almost_empty : count <= AE_THRESH
//   count        : occupancy (AW+1 bits)
//   overflow     : sticky, a write was rejected
//   underflow    : sticky, a read was rejected
//   clr_err      : clears overflow/underflow (a same-cycle new error wins)
// ---------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int AF_THRESH = DEPTH - 2,
    parameter  int AE_THRESH = 2,
    parameter  int FWFT      = 0,
    localparam int AW        = CLOG2(DEPTH)
) (
    input  logic              clk_master,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [AW:0]       w_count_nxt;
    logic [DATA_W-1:0] w_ram_rd;

    // A write into a full FIFO is only taken when a read frees a slot in
    // the same cycle; a read of an empty FIFO is always rejected, even if a
    // write lands in that same cycle.
    assign w_rd_acc = rd_en & ~r_empty;
    assign w_wr_acc = wr_en & (~r_full | w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next count so they move on the same
    // edge as count itself.
    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= (AW+1)'(AF_THRESH));
            r_almost_empty <= (w_count_nxt <= (AW+1)'(AE_THRESH));
        end
    end

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & ~w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en & ~w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_master (clk_master),
        .wr_en      (w_wr_acc),
        .wr_addr    (r_wr_ptr),
        .wr_data    (wr_data),
        .rd_addr    (r_rd_ptr),
        .rd_data    (w_ram_rd)
    );

    generate
        if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
            // Head of queue is always presented; valid whenever not empty.
            assign rd_data = w_ram_rd;
        end else begin : g_std
            logic [DATA_W-1:0] r_rd_data;

            always_ff @(posedge clk_master or posedge reset) begin
                if (reset) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= w_ram_rd;
                end
            end

            assign rd_data = r_rd_data;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Two instances: u_std (FWFT=0) and u_fwft (FWFT=1), DATA_W=8, DEPTH=16,
//   AF_THRESH=14, AE_THRESH=2. Expected read data for u_std is queued by the
//   driver and checked by an independent monitor one cycle after each read.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic clk_master = 1'b0;
    logic reset;

    always #5 clk_master = ~clk_master;

    // Standard-read instance
    logic       a_wr_en, a_rd_en, a_clr_err;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_full, a_empty, a_almost_full, a_almost_empty;
    logic       a_overflow, a_underflow;
    logic [4:0] a_count;

    // FWFT instance
    logic       b_wr_en, b_rd_en, b_clr_err;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_full, b_empty, b_almost_full, b_almost_empty;
    logic       b_overflow, b_underflow;
    logic [4:0] b_count;

    sync_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (16),
        .AF_THRESH (14),
        .AE_THRESH (2),
        .FWFT      (0)
    ) u_std (
        .clk_master   (clk_master),
        .reset        (reset),
        .wr_en        (a_wr_en),
        .wr_data      (a_wr_data),
        .rd_en        (a_rd_en),
        .rd_data      (a_rd_data),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_almost_full),
        .almost_empty (a_almost_empty),
        .count        (a_count),
        .overflow     (a_overflow),
        .underflow    (a_underflow),
        .clr_err      (a_clr_err)
    );

    sync_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (16),
        .AF_THRESH (14),
        .AE_THRESH (2),
        .FWFT      (1)
    ) u_fwft (
        .clk_master   (clk_master),
        .reset        (reset),
        .wr_en        (b_wr_en),
        .wr_data      (b_wr_data),
        .rd_en        (b_rd_en),
        .rd_data      (b_rd_data),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_almost_full),
        .almost_empty (b_almost_empty),
        .count        (b_count),
        .overflow     (b_overflow),
        .underflow    (b_underflow),
        .clr_err      (b_clr_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] expq [$];
    logic       mon_pend;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a read issued while an expectation is queued presents its
    // data the cycle after the edge that accepted it.
    always @(posedge clk_master) begin
        mon_pend = a_rd_en && (expq.size() != 0) && !reset;
        #1;
        if (mon_pend) begin
            mon_exp = expq.pop_front();
            check("std_rd_data", 32'(a_rd_data), 32'(mon_exp));
        end
    end

    task automatic a_cyc(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        @(negedge clk_master);
        a_wr_en = wr; a_wr_data = wd; a_rd_en = rd; a_clr_err = clr;
        @(posedge clk_master);
        #1;
        a_wr_en = 1'b0; a_wr_data = '0; a_rd_en = 1'b0; a_clr_err = 1'b0;
    endtask

    task automatic a_read(input logic [7:0] exp);
        expq.push_back(exp);
        a_cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic b_cyc(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        @(negedge clk_master);
        b_wr_en = wr; b_wr_data = wd; b_rd_en = rd; b_clr_err = clr;
        @(posedge clk_master);
        #1;
        b_wr_en = 1'b0; b_wr_data = '0; b_rd_en = 1'b0; b_clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wr_val;
        int unsigned rd_val;
        int          cnt;

        a_wr_en = 0; a_rd_en = 0; a_clr_err = 0; a_wr_data = '0;
        b_wr_en = 0; b_rd_en = 0; b_clr_err = 0; b_wr_data = '0;
        reset = 1'b1;
        #12;

        // Reset values
        check("rst_count",        32'(a_count), 0);
        check("rst_empty",        32'(a_empty), 1);
        check("rst_almost_empty", 32'(a_almost_empty), 1);
        check("rst_full",         32'(a_full), 0);
        check("rst_almost_full",  32'(a_almost_full), 0);
        check("rst_overflow",     32'(a_overflow), 0);
        check("rst_underflow",    32'(a_underflow), 0);
        check("rst_rd_data",      32'(a_rd_data), 0);
        check("rst_fwft_empty",   32'(b_empty), 1);
        @(negedge clk_master);
        reset = 1'b0;

        // Underflow, and clr_err losing to a same-cycle new error
        a_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_set",     32'(a_underflow), 1);
        check("unf_count",   32'(a_count), 0);
        check("unf_rd_data", 32'(a_rd_data), 0);
        check("unf_empty",   32'(a_empty), 1);
        a_cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("unf_clr_race", 32'(a_underflow), 1);
        a_cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(a_underflow), 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b1, 8'(i), 1'b0, 1'b0);
            check("fill_count", 32'(a_count), 32'(i + 1));
            check("fill_af",    32'(a_almost_full), ((i + 1) >= 14) ? 1 : 0);
            check("fill_full",  32'(a_full), ((i + 1) == 16) ? 1 : 0);
            check("fill_ae",    32'(a_almost_empty), ((i + 1) <= 2) ? 1 : 0);
        end

        // Overflow: 0xAA must be dropped
        a_cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set",   32'(a_overflow), 1);
        check("ovf_count", 32'(a_count), 16);
        check("ovf_full",  32'(a_full), 1);
        a_cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(a_overflow), 0);

        // Simultaneous read+write at full: 0x00 out, 0x55 in
        expq.push_back(8'h00);
        a_cyc(1'b1, 8'h55, 1'b1, 1'b0);
        check("sim_count", 32'(a_count), 16);
        check("sim_full",  32'(a_full), 1);
        check("sim_ovf",   32'(a_overflow), 0);
        check("sim_unf",   32'(a_underflow), 0);

        // Drain: 0x01..0x0F then 0x55
        for (int i = 1; i < 16; i++) begin
            a_read(8'(i));
            check("drain_count", 32'(a_count), 32'(16 - i));
            check("drain_af",    32'(a_almost_full), ((16 - i) >= 14) ? 1 : 0);
        end
        a_read(8'h55);
        check("drain_empty", 32'(a_empty), 1);
        check("drain_count0", 32'(a_count), 0);
        check("drain_ae",    32'(a_almost_empty), 1);
        a_cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("rd_data_hold", 32'(a_rd_data), 32'h55);

        // Wrap-around: prefill 3, then 10 x (W, W, R, R)
        wr_val = 32'h80;
        rd_val = 32'h80;
        cnt    = 0;
        for (int i = 0; i < 3; i++) begin
            a_cyc(1'b1, 8'(wr_val), 1'b0, 1'b0);
            wr_val++; cnt++;
        end
        check("wrap_pre_count", 32'(a_count), 3);
        check("wrap_pre_ae",    32'(a_almost_empty), 0);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (j < 2) begin
                    a_cyc(1'b1, 8'(wr_val), 1'b0, 1'b0);
                    wr_val++; cnt++;
                end else begin
                    a_read(8'(rd_val));
                    rd_val++; cnt--;
                end
                check("wrap_count", 32'(a_count), 32'(cnt));
                check("wrap_ae",    32'(a_almost_empty), 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            a_read(8'(rd_val));
            rd_val++; cnt--;
            check("wrap_tail_count", 32'(a_count), 32'(cnt));
            check("wrap_tail_ae",    32'(a_almost_empty), 1);
        end
        check("wrap_ovf", 32'(a_overflow), 0);
        check("wrap_unf", 32'(a_underflow), 0);
        check("wrap_q_drained", 32'(expq.size()), 0);

        // FWFT: word visible without rd_en
        b_cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        check("fwft_empty0",  32'(b_empty), 0);
        check("fwft_rd_data", 32'(b_rd_data), 32'h3C);
        check("fwft_count1",  32'(b_count), 1);
        b_cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("fwft_hold", 32'(b_rd_data), 32'h3C);
        b_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_pop_empty", 32'(b_empty), 1);
        check("fwft_pop_count", 32'(b_count), 0);
        b_cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_unf", 32'(b_underflow), 1);
        b_cyc(1'b1, 8'h10, 1'b0, 1'b0);
        b_cyc(1'b1, 8'h11, 1'b0, 1'b0);
        check("fwft_head",   32'(b_rd_data), 32'h10);
        check("fwft_count2", 32'(b_count), 2);

        // Asynchronous reset mid-burst, checked before any clock edge
        @(negedge clk_master);
        b_wr_en = 1'b1; b_wr_data = 8'h12;
        #2;
        reset = 1'b1;
        #1;
        check("mrst_count", 32'(b_count), 0);
        check("mrst_empty", 32'(b_empty), 1);
        check("mrst_unf",   32'(b_underflow), 0);
        check("mrst_ovf",   32'(b_overflow), 0);
        check("mrst_full",  32'(b_full), 0);
        b_wr_en = 1'b0; b_wr_data = '0;
        @(negedge clk_master);
        reset = 1'b0;
        b_cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("mrst_after_empty", 32'(b_empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
